// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle RV32I-subset datapath.
// Sequences FETCH/DECODE/execute/writeback and decodes all datapath controls
// from the current state (plus the opcode held in the instruction register).
// Optional feature: define MEM_HANDSHAKE_EN to make FETCH, MEMREAD and MEMWRITE
// wait for mem_ready; without it mem_ready is ignored.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       Branch,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    // Opcodes understood by the decoder
    localparam logic [6:0] OP_LOAD  = 7'd3;
    localparam logic [6:0] OP_STORE = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_ITYPE = 7'd19;
    localparam logic [6:0] OP_BRAN  = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;
    localparam logic [6:0] OP_JALR  = 7'd103;
    localparam logic [6:0] OP_AUIPC = 7'd23;
    localparam logic [6:0] OP_LUI   = 7'd55;

    // ALUSrcA / ALUSrcB / ResultSrc / ALUOp / ImmSrc encodings
    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;
    localparam logic [1:0] SA_ZERO  = 2'b11;
    localparam logic [1:0] SB_RS2   = 2'b00;
    localparam logic [1:0] SB_IMM   = 2'b01;
    localparam logic [1:0] SB_FOUR  = 2'b10;
    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_RDATA  = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;
    localparam logic [1:0] AO_ADD   = 2'b00;
    localparam logic [1:0] AO_CMP   = 2'b01;
    localparam logic [1:0] AO_FUNCT = 2'b10;
    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_U    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_J    = 3'b100;
    localparam logic [2:0] IMM_X    = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JALRADR  = 4'd11,
        S_UPPER    = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Full control word produced by the output decoder before reset gating
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic       branch;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       done;
    } ctl_t;

    state_t state_q, state_d;
    logic   rst_hold_q;   // set by reset; first FETCH runs only once it clears
    logic   mem_ok;       // memory access in a wait-capable state completes now
    logic   wr_en_ok;     // write enables permitted this cycle
    ctl_t   ctl;

`ifdef MEM_HANDSHAKE_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    // State register; reset parks in FETCH and holds one cycle past release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRAN:           state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JUMP;
                    OP_JALR:           state_d = S_JALRADR;
                    OP_AUIPC, OP_LUI:  state_d = S_UPPER;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_ALUWB;
            S_JALRADR:  state_d = S_JUMP;
            S_UPPER:    state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;  // unused encodings trap
        endcase
        if (rst_hold_q) state_d = S_FETCH;
    end

    // Moore output decode: everything idle except what the state drives
    always_comb begin
        ctl           = '0;
        ctl.imm_src   = IMM_X;
        case (state_q)
            S_FETCH: begin
                ctl.adr_src    = 1'b0;
                ctl.ir_write   = mem_ok;
                ctl.pc_write   = mem_ok;
                ctl.alu_src_a  = SA_PC;
                ctl.alu_src_b  = SB_FOUR;
                ctl.alu_op     = AO_ADD;
                ctl.result_src = RS_ALURES;
            end
            S_DECODE: begin
                ctl.alu_src_a = SA_OLDPC;
                ctl.alu_src_b = SB_IMM;
                ctl.alu_op    = AO_ADD;
                if (op == OP_BRAN)     ctl.imm_src = IMM_B;
                else if (op == OP_JAL) ctl.imm_src = IMM_J;
            end
            S_MEMADR: begin
                ctl.alu_src_a = SA_RS1;
                ctl.alu_src_b = SB_IMM;
                ctl.alu_op    = AO_ADD;
                ctl.imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctl.adr_src    = 1'b1;
                ctl.result_src = RS_ALUOUT;
            end
            S_MEMWB: begin
                ctl.result_src = RS_RDATA;
                ctl.reg_write  = 1'b1;
                ctl.done       = 1'b1;
            end
            S_MEMWRITE: begin
                ctl.adr_src    = 1'b1;
                ctl.result_src = RS_ALUOUT;
                ctl.mem_write  = mem_ok;
                ctl.done       = mem_ok;
            end
            S_EXECR: begin
                ctl.alu_src_a = SA_RS1;
                ctl.alu_src_b = SB_RS2;
                ctl.alu_op    = AO_FUNCT;
            end
            S_EXECI: begin
                ctl.alu_src_a = SA_RS1;
                ctl.alu_src_b = SB_IMM;
                ctl.imm_src   = IMM_I;
                ctl.alu_op    = AO_FUNCT;
            end
            S_ALUWB: begin
                ctl.result_src = RS_ALUOUT;
                ctl.reg_write  = 1'b1;
                ctl.done       = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a  = SA_RS1;
                ctl.alu_src_b  = SB_RS2;
                ctl.alu_op     = AO_CMP;
                ctl.result_src = RS_ALUOUT;
                ctl.branch     = 1'b1;
                ctl.done       = 1'b1;
            end
            S_JUMP: begin
                ctl.alu_src_a  = SA_OLDPC;
                ctl.alu_src_b  = SB_FOUR;
                ctl.alu_op     = AO_ADD;
                ctl.result_src = RS_ALUOUT;
                ctl.pc_write   = 1'b1;
            end
            S_JALRADR: begin
                ctl.alu_src_a = SA_RS1;
                ctl.alu_src_b = SB_IMM;
                ctl.imm_src   = IMM_I;
                ctl.alu_op    = AO_ADD;
            end
            S_UPPER: begin
                ctl.alu_src_a = (op == OP_LUI) ? SA_ZERO : SA_OLDPC;
                ctl.alu_src_b = SB_IMM;
                ctl.imm_src   = IMM_U;
                ctl.alu_op    = AO_ADD;
            end
            default: ;  // ILLEGAL and unused encodings: all idle
        endcase
    end

    // No architectural write while reset is low or in the parked cycle after it
    assign wr_en_ok   = rst_n & ~rst_hold_q;

    assign PCWrite    = ctl.pc_write  & wr_en_ok;
    assign IRWrite    = ctl.ir_write  & wr_en_ok;
    assign MemWrite   = ctl.mem_write & wr_en_ok;
    assign RegWrite   = ctl.reg_write & wr_en_ok;
    assign instr_done = ctl.done      & wr_en_ok;
    assign AdrSrc     = ctl.adr_src;
    assign Branch     = ctl.branch;
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign ResultSrc  = ctl.result_src;
    assign ALUOp      = ctl.alu_op;
    assign ImmSrc     = ctl.imm_src;
    assign state      = state_q;
    // ILLEGAL is only left through reset, so this is sticky by construction
    assign illegal    = (state_q == S_ILLEGAL);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table of per-opcode
// instruction summaries, hand-written reset/illegal/wait sequences and
// random opcode streams checked against a path-based reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Branch;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;
    logic       instr_done, illegal;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .Branch(Branch),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state(state),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef MEM_HANDSHAKE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    typedef struct packed {
        logic       pcw, irw, memw, regw, adr, br;
        logic [1:0] a, b, rs, alu;
        logic [2:0] imm;
        logic [3:0] st;
        logic       done, ill;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        int lat, regw, memw, pcw, br, done;
    } vec_t;

    int nvec = 0;
    int nfail = 0;
    int path_q[$];
    int r_lat, r_regw, r_memw, r_pcw, r_br, r_done, r_in5;
    logic [6:0] legal_ops [9] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'd103, 7'd23, 7'd55};

    function automatic ctl_t act();
        ctl_t c;
        c = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, Branch, ALUSrcA, ALUSrcB,
             ResultSrc, ALUOp, ImmSrc, state, instr_done, illegal};
        return c;
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_wait(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    // Instruction-level model: the ordered list of states an opcode visits
    function automatic void fill_path(input logic [6:0] o);
        case (o)
            7'd3:         path_q = '{0, 1, 2, 3, 4};
            7'd35:        path_q = '{0, 1, 2, 5};
            7'd51:        path_q = '{0, 1, 6, 8};
            7'd19:        path_q = '{0, 1, 7, 8};
            7'd99:        path_q = '{0, 1, 9};
            7'd111:       path_q = '{0, 1, 10, 8};
            7'd103:       path_q = '{0, 1, 11, 10, 8};
            7'd23, 7'd55: path_q = '{0, 1, 12, 8};
            default:      path_q = '{0, 1, 13};
        endcase
    endfunction

    // Control word each state must present, from the state descriptions
    function automatic ctl_t exp_ctl(input int s, input logic [6:0] o, input logic mr);
        ctl_t c;
        logic g;
        g = HS ? mr : 1'b1;
        c = '0; c.imm = 3'b111; c.st = 4'(s);
        case (s)
            0:  begin c.irw = g; c.pcw = g; c.b = 2'b10; c.rs = 2'b10; end
            1:  begin c.a = 2'b01; c.b = 2'b01;
                      c.imm = (o == 7'd99) ? 3'b011 : (o == 7'd111) ? 3'b100 : 3'b111; end
            2:  begin c.a = 2'b10; c.b = 2'b01; c.imm = (o == 7'd35) ? 3'b010 : 3'b000; end
            3:  begin c.adr = 1'b1; end
            4:  begin c.rs = 2'b01; c.regw = 1'b1; c.done = 1'b1; end
            5:  begin c.adr = 1'b1; c.memw = g; c.done = g; end
            6:  begin c.a = 2'b10; c.alu = 2'b10; end
            7:  begin c.a = 2'b10; c.b = 2'b01; c.imm = 3'b000; c.alu = 2'b10; end
            8:  begin c.regw = 1'b1; c.done = 1'b1; end
            9:  begin c.a = 2'b10; c.alu = 2'b01; c.br = 1'b1; c.done = 1'b1; end
            10: begin c.a = 2'b01; c.b = 2'b10; c.pcw = 1'b1; end
            11: begin c.a = 2'b10; c.b = 2'b01; c.imm = 3'b000; end
            12: begin c.a = (o == 7'd55) ? 2'b11 : 2'b01; c.b = 2'b01; c.imm = 3'b001; end
            13: begin c.ill = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_ctl(input string nm, input ctl_t a, input ctl_t e);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Reset for n edges, then release; leaves the bench in the first live FETCH
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("rst state", 32'(state), 32'd0);
            chk("rst illegal", 32'(illegal), 32'd0);
            chk("rst wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        end
        rst_n = 1'b1; #1;
        chk("release wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(posedge clk); #1;
        chk("release state", 32'(state), 32'd0);
    endtask

    // Run one instruction from FETCH; stall>=0 holds mem_ready low for the
    // first stall cycles of each state, stall<0 randomizes it
    task automatic run_instr(input logic [6:0] o, input int stall);
        int k;
        logic mr;
        int s;
        op = o;
        fill_path(o);
        r_lat = 0; r_regw = 0; r_memw = 0; r_pcw = 0; r_br = 0; r_done = 0; r_in5 = 0;
        foreach (path_q[i]) begin
            s = path_q[i];
            k = 0;
            forever begin
                if (stall < 0) mr = (k >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                else           mr = (k >= stall);
                mem_ready = mr; #1;
                chk_ctl($sformatf("op%0d state%0d cyc%0d", o, s, k), act(), exp_ctl(s, o, mr));
                r_lat++;
                r_regw += int'(RegWrite); r_memw += int'(MemWrite);
                r_pcw  += int'(PCWrite);  r_br   += int'(Branch);
                r_done += int'(instr_done);
                if (s == 5) r_in5++;
                @(posedge clk); #1;
                k++;
                if (!(HS && is_wait(s) && !mr)) break;
            end
        end
    endtask

    initial begin
        vec_t tbl[9];
        logic [6:0] o;

        tbl = '{'{7'd3,   5, 1, 0, 1, 0, 1},
                '{7'd35,  4, 0, 1, 1, 0, 1},
                '{7'd51,  4, 1, 0, 1, 0, 1},
                '{7'd19,  4, 1, 0, 1, 0, 1},
                '{7'd99,  3, 0, 0, 1, 1, 1},
                '{7'd111, 4, 1, 0, 2, 0, 1},
                '{7'd103, 5, 1, 0, 2, 0, 1},
                '{7'd23,  4, 1, 0, 1, 0, 1},
                '{7'd55,  4, 1, 0, 1, 0, 1}};

        do_reset(3);

        // Table: per-opcode latency and write/retire counts, no wait states
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, 0);
            chk($sformatf("op%0d latency", tbl[i].op), 32'(r_lat),  32'(tbl[i].lat));
            chk($sformatf("op%0d regwrite", tbl[i].op), 32'(r_regw), 32'(tbl[i].regw));
            chk($sformatf("op%0d memwrite", tbl[i].op), 32'(r_memw), 32'(tbl[i].memw));
            chk($sformatf("op%0d pcwrite", tbl[i].op), 32'(r_pcw),  32'(tbl[i].pcw));
            chk($sformatf("op%0d branch", tbl[i].op), 32'(r_br),   32'(tbl[i].br));
            chk($sformatf("op%0d done", tbl[i].op), 32'(r_done), 32'(tbl[i].done));
        end

        // Illegal opcode: trap, stay put with writes off, reset clears it
        run_instr(7'h7F, 0);
        repeat (10) begin
            mem_ready = 1'($urandom_range(0, 1)); #1;
            chk("illegal state", 32'(state), 32'd13);
            chk("illegal flag", 32'(illegal), 32'd1);
            chk("illegal wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite, instr_done}), 32'd0);
            @(posedge clk); #1;
        end
        do_reset(1);

        // Reset while in MEMREAD (mem_ready low): abort, no RegWrite
        op = 7'd3; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort pre state", 32'(state), 32'd3);
        mem_ready = 1'b0;
        rst_n = 1'b0; #1;
        chk("abort regwrite", 32'(RegWrite), 32'd0);
        @(posedge clk); #1;
        chk("abort state", 32'(state), 32'd0);
        chk("abort wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1; #1;
        chk("abort hold wen", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        @(posedge clk); #1;
        chk("abort fetch state", 32'(state), 32'd0);
        chk("abort fetch pcw", 32'(PCWrite), 32'd1);

        // Store with mem_ready low for 3 cycles in each memory state
        run_instr(7'd35, 3);
        chk("store memwrite cycles", 32'(r_in5), HS ? 32'd4 : 32'd1);
        chk("store memwrite count", 32'(r_memw), 32'd1);
        chk("store pcwrite count", 32'(r_pcw), 32'd1);
        chk("store done count", 32'(r_done), 32'd1);

        // Random opcode stream with random mem_ready
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                do o = 7'($urandom_range(0, 127)); while (is_legal(o));
                run_instr(o, -1);
                #1;
                chk("rand illegal flag", 32'(illegal), 32'd1);
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                o = legal_ops[$urandom_range(0, 8)];
                run_instr(o, -1);
                chk($sformatf("rand op%0d done", o), 32'(r_done), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
